cla_mp_sequencer: RTL and testbench
===================================

Name: cla_mp_sequencer

Overview:
- Multi-precision add/subtract sequencer built around one instance of the team's 16-bit carry-lookahead adder (CLA_16bit).
- Accepts WORDS×16-bit operands through a valid/ready handshake and feeds them to the shared CLA one 16-bit word per cycle, least-significant word first.
- Chains the carry between words through a register, then returns the full result with a carry/borrow flag and a signed-overflow flag.
- Sits between the datapath issue logic and the CLA. It is the only user of that adder instance.

Parameters:
- WORDS, 4, number of 16-bit words per operand. Legal values are 1 to 16; operand width is W = 16*WORDS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_valid  input  1  request carries valid operands.
- start_ready  output  1  sequencer can accept a request.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- sub  input  1  0 = A+B, 1 = A−B.
- res_valid  output  1  result outputs are valid.
- res_ready  input  1  consumer accepts the result.
- result  output  W  sum or difference.
- cout  output  1  final carry out. On sub, 1 means no borrow (A ≥ B unsigned).
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low): takes effect immediately, asynchronously.
  - State goes to IDLE; word counter, carry register, operand registers, result, cout and ovf clear to 0.
  - res_valid = 0, busy = 0, start_ready = 0 while rst_n is low.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid & start_ready at an edge: latch op_a, op_b and sub; set counter k = 0; load carry register with sub; go to RUN.
  - start_valid is ignored in every other state.
- RUN (exactly WORDS cycles):
  - CLA inputs are a = A[16k+15:16k], b = B[16k+15:16k] XOR {16{sub_l}}, cin = carry register.
  - At each edge: result word k ← CLA sum; carry register ← CLA cout; k increments.
  - On the edge where k = WORDS−1:
    - cout ← CLA cout.
    - ovf ← (a[15] == b'[15]) & (sum[15] != a[15]), where b' is the inverted-if-sub B word.
    - State goes to DONE.
- Latency: res_valid is high in the cycle that begins WORDS edges after the accept edge. With WORDS = 4, accept at edge 0 gives res_valid after edge 4.
- DONE:
  - res_valid = 1.
  - result, cout and ovf are held stable until res_valid & res_ready at an edge, then the state goes to IDLE.
  - No overlap: a new request can be accepted no earlier than the edge after the result handshake. Peak throughput is one operation per WORDS+2 cycles.
- Zero-extension rule: result is W bits exactly, and carry beyond the MSW appears only on cout.
- The CLA instance is driven only in RUN. In IDLE and DONE its inputs are 0.
- Outputs are registered. start_ready, res_valid and busy are decoded directly from the state register.
- Reset mid-RUN or mid-DONE: the operation is discarded and no partial result is ever presented. The next operation after reset must not see a stale carry.
- WORDS = 1 degenerates to one RUN cycle and must work.

Test Plan (WORDS=4):
- Reset/idle: hold rst_n low for 3 cycles, then release.
  - Required: start_ready = 0 during reset and 1 after.
  - Required: res_valid = 0, result = 0, busy = 0.
- Ripple across words: A = 0x0000FFFFFFFFFFFF, B = 0x1, sub = 0.
  - Required: result = 0x0001000000000000, cout = 0, ovf = 0.
  - Required: res_valid rises exactly 4 edges after the accept edge.
- Subtract with borrow: A = 0x5, B = 0x7, sub = 1.
  - Required: result = 0xFFFFFFFFFFFFFFFE, cout = 0, ovf = 0.
  - Follow-up: A = 0x7, B = 0x5, sub = 1 gives result = 0x2, cout = 1.
- Overflow vs carry:
  - A = 0x7FFFFFFFFFFFFFFF + B = 0x1 gives result = 0x8000000000000000, ovf = 1, cout = 0.
  - A = 0xFFFFFFFFFFFFFFFF + B = 0x1 gives result = 0x0, ovf = 0, cout = 1.
- Backpressure: hold res_ready = 0 for 5 cycles in DONE while start_valid = 1 with new operands.
  - Required: result, cout and ovf stay unchanged; start_ready = 0 and the new request is not accepted.
  - Required: after res_ready = 1, the state returns to IDLE and the pending request is accepted on the following edge.
- Reset mid-run: pulse rst_n low during the 2nd RUN cycle of 0xFFFF...+1.
  - Required: res_valid = 0 and result = 0 immediately.
  - Required: the next request 0x1 + 0x1 returns exactly 0x2 with cout = 0.

Source files
------------

// File: rtl/cla_mp_sequencer.sv
// Multi-precision add/subtract sequencer: streams WORDS x 16-bit operand words, LSW first,
// through a single shared 16-bit carry-lookahead adder and chains the carry through a register.

module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;

  // Two-level lookahead: 4-bit groups generate/propagate, then a carry chain across groups.
  always_comb begin
    logic grp_cin;
    logic bit_c;
    g       = a & b;
    p       = a ^ b;
    sum     = '0;
    grp_cin = cin;
    for (int j = 0; j < 4; j++) begin
      grp_p[j] = &p[4*j +: 4];
      grp_g[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (&p[4*j+2 +: 2] & g[4*j+1])
               | (&p[4*j+1 +: 3] & g[4*j]);
      bit_c = grp_cin;
      for (int i = 0; i < 4; i++) begin
        sum[4*j+i] = p[4*j+i] ^ bit_c;
        bit_c      = g[4*j+i] | (p[4*j+i] & bit_c);
      end
      grp_cin = grp_g[j] | (grp_p[j] & grp_cin);
    end
    cout = grp_cin;
  end

endmodule

module cla_mp_sequencer #(
  parameter int unsigned WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [16*WORDS-1:0] op_a,
  input  logic [16*WORDS-1:0] op_b,
  input  logic                sub,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [16*WORDS-1:0] result,
  output logic                cout,
  output logic                ovf,
  output logic                busy
);

  localparam int unsigned W  = 16 * WORDS;
  localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] KLast = KW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          sub_q, sub_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [15:0]   a_word;
  logic [15:0]   b_word;
  logic [15:0]   cla_a;
  logic [15:0]   cla_b;
  logic          cla_cin;
  logic [15:0]   cla_sum;
  logic          cla_cout;
  logic          run;

  assign run = (state_q == StRun);

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int i = 0; i < int'(WORDS); i++) begin
      if (k_q == KW'(i)) begin
        a_word = a_q[16*i +: 16];
        b_word = b_q[16*i +: 16];
      end
    end
  end

  // Adder inputs are held at zero outside RUN.
  assign cla_a   = run ? a_word : 16'h0000;
  assign cla_b   = run ? (b_word ^ {16{sub_q}}) : 16'h0000;
  assign cla_cin = run ? carry_q : 1'b0;

  CLA_16bit u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (cla_cin),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = sub;
          k_d     = '0;
          carry_d = sub;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int i = 0; i < int'(WORDS); i++) begin
          if (k_q == KW'(i)) begin
            result_d[16*i +: 16] = cla_sum;
          end
        end
        carry_d = cla_cout;
        k_d     = k_q + KW'(1);
        if (k_q == KLast) begin
          cout_d  = cla_cout;
          ovf_d   = (cla_a[15] == cla_b[15]) & (cla_sum[15] != cla_a[15]);
          k_d     = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      k_q      <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // start_ready is masked by rst_n so no request looks acceptable while reset is held.
  assign start_ready = (state_q == StIdle) & rst_n;
  assign res_valid   = (state_q == StDone);
  assign busy        = (state_q == StRun) | (state_q == StDone);
  assign result      = result_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Directed bench for cla_mp_sequencer with WORDS = 4 (64-bit operands).

module tb_cla_mp_sequencer;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 16 * WORDS;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  cla_mp_sequencer #(.WORDS(WORDS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept at one edge, wait for res_valid, check latency and result; leaves DUT in DONE.
  task automatic issue(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s);
    int n;
    @(negedge clk);
    op_a        = a;
    op_b        = b;
    sub         = s;
    start_valid = 1'b1;
    chk({tag, "_ready"}, W'(start_ready), W'(1));
    @(posedge clk);
    #1 start_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (res_valid) break;
    end
    chk({tag, "_latency"}, W'(n), W'(WORDS));
  endtask

  task automatic finish_op(input string tag, input logic [W-1:0] exp_res, input logic exp_c,
                           input logic exp_v);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_cout"}, W'(cout), W'(exp_c));
    chk({tag, "_ovf"}, W'(ovf), W'(exp_v));
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    chk({tag, "_idle"}, W'({res_valid, busy, start_ready}), W'(3'b001));
  endtask

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    op_a        = '0;
    op_b        = '0;
    sub         = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", W'(start_ready), W'(0));
    chk("rst_valid", W'(res_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", W'(start_ready), W'(1));

    issue("ripple", 64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    finish_op("ripple", 64'h0001_0000_0000_0000, 1'b0, 1'b0);

    issue("borrow", 64'h5, 64'h7, 1'b1);
    finish_op("borrow", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

    issue("noborrow", 64'h7, 64'h5, 1'b1);
    finish_op("noborrow", 64'h2, 1'b1, 1'b0);

    issue("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    finish_op("ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    issue("carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    finish_op("carry", 64'h0, 1'b1, 1'b0);

    // Backpressure: result held in DONE while a new request waits.
    issue("bp", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    @(negedge clk);
    op_a        = 64'h0000_0000_1234_0000;
    op_b        = 64'h0000_0000_0000_5678;
    sub         = 1'b0;
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_result", result, 64'h8000_0000_0000_0000);
      chk("bp_hold_flags", W'({cout, ovf, res_valid, start_ready}), W'(4'b0110));
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    chk("bp_back_idle", W'({res_valid, busy, start_ready}), W'(3'b001));
    @(posedge clk);
    #1 start_valid = 1'b0;
    chk("bp_pending_accepted", W'({busy, start_ready}), W'(2'b10));
    repeat (WORDS) @(posedge clk);
    #1 chk("bp_pending_valid", W'(res_valid), W'(1));
    finish_op("bp_pending", 64'h0000_0000_1234_5678, 1'b0, 1'b0);

    // Reset during the second RUN cycle.
    @(negedge clk);
    op_a        = 64'hFFFF_FFFF_FFFF_FFFF;
    op_b        = 64'h1;
    sub         = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", W'(res_valid), W'(0));
    chk("midrst_result", result, '0);
    chk("midrst_busy", W'(busy), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    issue("after_rst", 64'h1, 64'h1, 1'b0);
    finish_op("after_rst", 64'h2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
